// File: rtl/dcache_miss_handler.sv
// Data-cache miss handler: one outstanding line refill, fetched as a 4-beat INCR read burst
// and delivered to the cache as a single 16 B fill, with an in-flight line probe for the load pipe.

module dcache_miss_handler_chk (
   input logic clk,
   input logic rst_n,
   input logic miss_ready,
   input logic busy,
   input logic mem_arvalid,
   input logic mem_rready,
   input logic fill_valid,
   input logic pend_hit
);
   ap_ready_idle : assert property (@(posedge clk) disable iff (!rst_n) miss_ready == !busy);
   ap_phase_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                    $onehot0({mem_arvalid, mem_rready, fill_valid}));
   ap_probe_busy : assert property (@(posedge clk) disable iff (!rst_n) pend_hit |-> busy);
endmodule

module dcache_miss_handler (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         miss_valid,
   input  logic [27:0]  miss_addr,
   output logic         miss_ready,
   output logic         mem_arvalid,
   output logic [31:0]  mem_araddr,
   output logic [7:0]   mem_arlen,
   output logic [2:0]   mem_arsize,
   output logic [1:0]   mem_arburst,
   input  logic         mem_arready,
   input  logic         mem_rvalid,
   input  logic [31:0]  mem_rdata,
   input  logic         mem_rlast,
   output logic         mem_rready,
   output logic         fill_valid,
   output logic [27:0]  fill_addr,
   output logic [127:0] fill_data,
   input  logic         fill_ready,
   input  logic [27:0]  q_addr,
   output logic         pend_hit,
   output logic         busy,
   output logic         err
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      FILL = 2'd3
   } state_t;

   state_t       state_r;
   state_t       state_next_s;
   logic [1:0]   cnt_r;
   logic [27:0]  line_addr_r;
   logic [31:0]  word_r [4];
   logic         err_r;
   logic         accept_s;
   logic         beat_s;
   logic         last_beat_s;

   // rlast must coincide exactly with the fourth beat; anything else is a framing fault
   function automatic logic framing_error(input logic rlast, input logic [1:0] cnt);
      framing_error = rlast ^ (cnt == 2'd3);
   endfunction

   // Handshake qualifiers derived from the current state
   always_comb begin
      accept_s    = (state_r == IDLE) && miss_valid;
      beat_s      = (state_r == R) && mem_rvalid;
      last_beat_s = beat_s && (cnt_r == 2'd3);
   end

   // Next-state decode; the beat count alone ends the burst
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (miss_valid) state_next_s = AR;
            else            state_next_s = IDLE;
         end
         AR: begin
            if (mem_arready) state_next_s = R;
            else             state_next_s = AR;
         end
         R: begin
            if (last_beat_s) state_next_s = FILL;
            else             state_next_s = R;
         end
         FILL: begin
            if (fill_ready) state_next_s = IDLE;
            else            state_next_s = FILL;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_next_s;
   end

   // Line address latch, beat counter and line assembly buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= 2'd0;
         line_addr_r <= 28'd0;
         for (int i = 0; i < 4; i++) word_r[i] <= 32'd0;
      end else if (accept_s) begin
         cnt_r       <= 2'd0;
         line_addr_r <= miss_addr;
      end else if (beat_s) begin
         word_r[cnt_r] <= mem_rdata;
         cnt_r         <= cnt_r + 2'd1;
      end else begin
         cnt_r       <= cnt_r;
         line_addr_r <= line_addr_r;
      end
   end

   // Sticky framing error, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     err_r <= 1'b0;
      else if (beat_s && framing_error(mem_rlast, cnt_r)) err_r <= 1'b1;
      else                                            err_r <= err_r;
   end

   assign miss_ready  = (state_r == IDLE);
   assign busy        = (state_r != IDLE);
   assign mem_arvalid = (state_r == AR);
   assign mem_araddr  = {line_addr_r, 4'h0};
   assign mem_arlen   = 8'd3;
   assign mem_arsize  = 3'b010;
   assign mem_arburst = 2'b01;
   assign mem_rready  = (state_r == R);
   assign fill_valid  = (state_r == FILL);
   assign fill_addr   = line_addr_r;
   assign fill_data   = {word_r[3], word_r[2], word_r[1], word_r[0]};
   assign pend_hit    = busy && (q_addr == line_addr_r);
   assign err         = err_r;

   dcache_miss_handler_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .miss_ready  (miss_ready),
      .busy        (busy),
      .mem_arvalid (mem_arvalid),
      .mem_rready  (mem_rready),
      .fill_valid  (fill_valid),
      .pend_hit    (pend_hit)
   );
endmodule
